// File: rtl/tc_ram_dma.sv
// rtl/tc_ram_dma.sv - FILL/COPY block-transfer initiator for the fast RAM load/save port.
module tc_ram_dma #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [15:0] cmd_src,
    input  logic [15:0] cmd_dst,
    input  logic [15:0] cmd_len,
    input  logic [63:0] cmd_fill,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_done,
    output logic [15:0] ram_address,
    output logic        ram_load,
    output logic        ram_save,
    output logic [63:0] ram_in0,
    output logic [63:0] ram_in1,
    output logic [63:0] ram_in2,
    output logic [63:0] ram_in3,
    input  logic [63:0] ram_out0,
    input  logic [63:0] ram_out1,
    input  logic [63:0] ram_out2,
    input  logic [63:0] ram_out3
);

    localparam logic [16:0] DEPTH = 17'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, FILL, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [15:0]   src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
    logic [15:0]   wd_q, wd_d, addr_q, addr_d;
    logic [63:0]   fill_q, fill_d;
    logic [255:0]  hold_q, hold_d, din_q, din_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          load_q, load_d, save_q, save_d;
    logic          reject;
    logic [15:0]   idx_nxt;

    // Operands are always below MEM_WORDS, so one conditional subtract wraps the sum.
    function automatic logic [15:0] wrap(input logic [15:0] base, input logic [15:0] off);
        logic [16:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= DEPTH) s = s - DEPTH;
        return s[15:0];
    endfunction

    assign reject  = ({1'b0, cmd_dst} >= DEPTH) || (cmd_op && ({1'b0, cmd_src} >= DEPTH))
                     || ({1'b0, cmd_len} > DEPTH);
    assign idx_nxt = idx_q + 16'd1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    src_d  = cmd_src;
                    dst_d  = cmd_dst;
                    len_d  = cmd_len;
                    fill_d = cmd_fill;
                    idx_d  = 16'd0;
                    wd_d   = 16'd0;
                    if (reject) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (cmd_len == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = cmd_op ? RD : FILL;
                    end
                end
            end
            FILL, WR: begin
                wd_d = wd_q + 16'd1;
                if (idx_nxt == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_nxt;
                    state_d = (state_q == FILL) ? FILL : RD;
                end
            end
            RD: begin
                hold_d  = {ram_out3, ram_out2, ram_out1, ram_out0};
                state_d = WR;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the upcoming state.
        busy_d = (state_d != IDLE);
        load_d = (state_d == RD);
        save_d = (state_d == FILL) || (state_d == WR);
        addr_d = addr_q;
        din_d  = 256'd0;
        case (state_d)
            FILL: begin
                addr_d = wrap(dst_d, idx_d);
                din_d  = {192'd0, fill_d};
            end
            RD:      addr_d = wrap(src_d, idx_d);
            WR: begin
                addr_d = wrap(dst_d, idx_d);
                din_d  = hold_d;
            end
            default: addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            src_q   <= 16'd0;
            dst_q   <= 16'd0;
            len_q   <= 16'd0;
            fill_q  <= 64'd0;
            idx_q   <= 16'd0;
            wd_q    <= 16'd0;
            hold_q  <= 256'd0;
            addr_q  <= 16'd0;
            din_q   <= 256'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            save_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            load_q  <= load_d;
            save_q  <= save_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign words_done  = wd_q;
    assign ram_address = addr_q;
    assign ram_load    = load_q;
    assign ram_save    = save_q;
    assign ram_in0     = din_q[63:0];
    assign ram_in1     = din_q[127:64];
    assign ram_in2     = din_q[191:128];
    assign ram_in3     = din_q[255:192];

endmodule

// File: tb/tb_tc_ram_dma.sv
// tb/tb_tc_ram_dma.sv - scoreboard bench for tc_ram_dma with a behavioural fast RAM.
module tb_tc_ram_dma;

    localparam int K_LOAD = 0, K_SAVE = 1, K_DONE = 2, K_ERR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [15:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
    logic [63:0] cmd_fill = '0;
    logic        cmd_ready, busy, done, err, ram_load, ram_save;
    logic [15:0] words_done, ram_address;
    logic [63:0] ram_in0, ram_in1, ram_in2, ram_in3;
    logic [63:0] ram_out0, ram_out1, ram_out2, ram_out3;

    logic [255:0] mem [0:255];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int           cyc;
        int           kind;
        int           addr;
        logic [255:0] data;
    } exp_t;
    exp_t q[$];

    tc_ram_dma #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .ram_address(ram_address), .ram_load(ram_load), .ram_save(ram_save),
        .ram_in0(ram_in0), .ram_in1(ram_in1), .ram_in2(ram_in2), .ram_in3(ram_in3),
        .ram_out0(ram_out0), .ram_out1(ram_out1), .ram_out2(ram_out2), .ram_out3(ram_out3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign {ram_out3, ram_out2, ram_out1, ram_out0} = mem[ram_address[7:0]];
    always @(negedge clk)
        if (ram_save) mem[ram_address[7:0]] <= {ram_in3, ram_in2, ram_in1, ram_in0};

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [255:0] lanes(input logic [63:0] v);
        return {v, v, v, v};
    endfunction

    function automatic void expect_ev(input int c, input int k, input int a, input logic [255:0] d);
        exp_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        int   n;
        int   kind;
        exp_t e;
        if (mon_en) begin
            n = int'(ram_load) + int'(ram_save) + int'(done) + int'(err);
            kind = ram_load ? K_LOAD : ram_save ? K_SAVE : done ? K_DONE : K_ERR;
            if (n > 1) begin
                chk("single_event", n, 1);
            end else if (n == 1) begin
                if (q.size() == 0) begin
                    chk("unexpected_event_kind", kind, 99);
                end else begin
                    e = q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_kind", kind, e.kind);
                    if (kind == K_LOAD || kind == K_SAVE) chk("ev_addr", ram_address, e.addr);
                    if (kind == K_SAVE) chk("ev_data", {ram_in3, ram_in2, ram_in1, ram_in0}, e.data);
                end
            end
        end
    end

    task automatic start(input logic op, input int src, input int dst, input int len,
                         input logic [63:0] fill, output int base);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_op = op; cmd_src = 16'(src); cmd_dst = 16'(dst); cmd_len = 16'(len);
        cmd_fill = fill; cmd_valid = 1'b1;
        base = cyc + 1;
    endtask

    task automatic wait_ready(input int base, input int exp_cycle, input string name);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        chk({name, "_ready_cycle"}, cyc - base, exp_cycle);
    endtask

    initial begin
        int b;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = lanes(64'd1);
        mem[1] = lanes(64'd2);
        mem[5] = lanes(64'd7);
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_flags", {busy, done, err, ram_load, ram_save}, 0);
        chk("rst_addr_wd", {ram_address, words_done}, 0);
        chk("rst_din", {ram_in3, ram_in2, ram_in1, ram_in0}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // FILL dst=10 len=3
        start(1'b0, 0, 10, 3, 64'hA5, b);
        for (int i = 0; i < 3; i++) expect_ev(b + i, K_SAVE, 10 + i, {192'd0, 64'hA5});
        expect_ev(b + 3, K_DONE, 0, 0);
        wait_ready(b, 4, "fill");
        chk("fill_wd", words_done, 3);
        for (int i = 10; i < 13; i++) chk("fill_mem", mem[i], {192'd0, 64'hA5});

        // COPY src=0 dst=100 len=2
        start(1'b1, 0, 100, 2, 64'hFFFF, b);
        expect_ev(b + 0, K_LOAD, 0, 0);
        expect_ev(b + 1, K_SAVE, 100, lanes(64'd1));
        expect_ev(b + 2, K_LOAD, 1, 0);
        expect_ev(b + 3, K_SAVE, 101, lanes(64'd2));
        expect_ev(b + 4, K_DONE, 0, 0);
        wait_ready(b, 5, "copy");
        chk("copy_wd", words_done, 2);
        chk("copy_mem100", mem[100], lanes(64'd1));
        chk("copy_mem101", mem[101], lanes(64'd2));

        // FILL wrapping past the top of memory
        start(1'b0, 0, 254, 4, 64'h1234, b);
        expect_ev(b + 0, K_SAVE, 254, {192'd0, 64'h1234});
        expect_ev(b + 1, K_SAVE, 255, {192'd0, 64'h1234});
        expect_ev(b + 2, K_SAVE, 0, {192'd0, 64'h1234});
        expect_ev(b + 3, K_SAVE, 1, {192'd0, 64'h1234});
        expect_ev(b + 4, K_DONE, 0, 0);
        wait_ready(b, 5, "wrap");
        chk("wrap_wd", words_done, 4);
        chk("wrap_mem0", mem[0], {192'd0, 64'h1234});

        // Overlapping forward COPY replicates word 5
        start(1'b1, 5, 6, 3, 64'h0, b);
        for (int i = 0; i < 3; i++) begin
            expect_ev(b + 2 * i, K_LOAD, 5 + i, 0);
            expect_ev(b + 2 * i + 1, K_SAVE, 6 + i, lanes(64'd7));
        end
        expect_ev(b + 6, K_DONE, 0, 0);
        wait_ready(b, 7, "ovl");
        for (int i = 6; i < 9; i++) chk("ovl_mem", mem[i], lanes(64'd7));

        // Zero length
        start(1'b0, 0, 3, 0, 64'h99, b);
        expect_ev(b, K_DONE, 0, 0);
        wait_ready(b, 1, "len0");
        chk("len0_wd", words_done, 0);
        chk("len0_mem", mem[3], 0);

        // Rejections
        start(1'b0, 0, 256, 1, 64'h77, b);
        expect_ev(b, K_ERR, 0, 0);
        wait_ready(b, 1, "rej_dst");
        start(1'b1, 0, 0, 257, 64'h0, b);
        expect_ev(b, K_ERR, 0, 0);
        wait_ready(b, 1, "rej_len");
        start(1'b1, 300, 0, 1, 64'h0, b);
        expect_ev(b, K_ERR, 0, 0);
        wait_ready(b, 1, "rej_src");
        chk("rej_mem256_guard", mem[0], {192'd0, 64'h1234});

        // Reset in the middle of a FILL
        start(1'b0, 0, 20, 10, 64'h55, b);
        for (int i = 0; i < 5; i++) expect_ev(b + i, K_SAVE, 20 + i, {192'd0, 64'h55});
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_flags", {busy, done, err, ram_load, ram_save}, 0);
        chk("abort_addr_wd", {ram_address, words_done}, 0);
        chk("abort_din", {ram_in3, ram_in2, ram_in1, ram_in0}, 0);
        @(negedge clk);
        chk("abort_no_accept", busy, 0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_mem24", mem[24], {192'd0, 64'h55});
        chk("abort_mem25", mem[25], 0);

        start(1'b0, 0, 30, 1, 64'h9, b);
        expect_ev(b, K_SAVE, 30, {192'd0, 64'h9});
        expect_ev(b + 1, K_DONE, 0, 0);
        wait_ready(b, 2, "after_rst");
        chk("after_rst_mem", mem[30], {192'd0, 64'h9});
        chk("after_rst_wd", words_done, 1);

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
